// File: rtl/data_distribute_pkg.sv
// rtl/data_distribute_pkg.sv - channel tag constants and steer FSM state for data_distribute
package data_distribute_pkg;

  localparam logic [1:0] CH_A    = 2'b00;
  localparam logic [1:0] CH_B    = 2'b01;
  localparam logic [1:0] CH_C    = 2'b10;
  localparam logic [1:0] CH_NONE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/data_distribute_async_fifo_gray.sv
// rtl/data_distribute_async_fifo_gray.sv - dual-clock FIFO with Gray pointers and a valid-only registered read port
module async_fifo_gray #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          wr_clk_i,
  input  logic          rd_clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_vld_o
);

  localparam int PW = AW + 1;

  logic [DW-1:0] mem_q [2**AW];

  logic [1:0]    wrst_q, rrst_q;
  logic          wrst_n, rrst_n;
  logic [PW-1:0] wbin_q, wgray_q, wbin_d;
  logic [PW-1:0] rbin_q, rgray_q, rbin_d;
  logic [PW-1:0] rgray_s1_q, rgray_s2_q;
  logic [PW-1:0] wgray_s1_q, wgray_s2_q;
  logic          wr_do, rd_do, empty;

  // Reset asserts at once in both domains, releases after two local clock edges.
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wrst_q <= 2'b00;
    else          wrst_q <= {wrst_q[0], 1'b1};
  end

  always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rrst_q <= 2'b00;
    else          rrst_q <= {rrst_q[0], 1'b1};
  end

  assign wrst_n = wrst_q[1];
  assign rrst_n = rrst_q[1];

  assign full_o = (wgray_q == {~rgray_s2_q[AW:AW-1], rgray_s2_q[AW-2:0]});
  assign wr_do  = wr_en_i & ~full_o;
  assign wbin_d = wbin_q + {{AW{1'b0}}, wr_do};

  always_ff @(posedge wr_clk_i or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      rgray_s1_q <= '0;
      rgray_s2_q <= '0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wbin_d ^ (wbin_d >> 1);
      rgray_s1_q <= rgray_q;
      rgray_s2_q <= rgray_s1_q;
    end
  end

  always_ff @(posedge wr_clk_i) begin
    if (wr_do) mem_q[wbin_q[AW-1:0]] <= wr_data_i;
  end

  assign empty  = (rgray_q == wgray_s2_q);
  assign rd_do  = ~empty;
  assign rbin_d = rbin_q + {{AW{1'b0}}, rd_do};

  always_ff @(posedge rd_clk_i or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      wgray_s1_q <= '0;
      wgray_s2_q <= '0;
      rd_data_o  <= '0;
      rd_vld_o   <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rbin_d ^ (rbin_d >> 1);
      wgray_s1_q <= wgray_q;
      wgray_s2_q <= wgray_s1_q;
      rd_vld_o   <= rd_do;
      if (rd_do) rd_data_o <= mem_q[rbin_q[AW-1:0]];
    end
  end

endmodule

// File: rtl/data_distribute.sv
// rtl/data_distribute.sv - steers a tagged clkd stream into three per-channel async FIFOs
// Optional discarded-word counter port err_cnt is built when DIST_ERR_CNT_EN is defined.
module data_distribute
  import data_distribute_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clkd,
  input  logic          rst_n,
  input  logic          clka,
  input  logic          clkb,
  input  logic          clkc,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic [1:0]    din_channel,
  output logic          din_rdy,
  output logic [DW-1:0] dout_a,
  output logic          dout_a_vld,
  output logic [DW-1:0] dout_b,
  output logic          dout_b_vld,
  output logic [DW-1:0] dout_c,
  output logic          dout_c_vld
`ifdef DIST_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  logic [1:0]    rst_sync_q;
  logic          rst_ok;
  state_t        state_q;
  logic [DW-1:0] stage_data_q;
  logic [1:0]    stage_chan_q;
  logic [2:0]    full, wr_en;
  logic          tgt_full, accept, drain;

  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ok = rst_sync_q[1];

  always_comb begin
    tgt_full = 1'b1;
    case (stage_chan_q)
      CH_A:    tgt_full = full[0];
      CH_B:    tgt_full = full[1];
      CH_C:    tgt_full = full[2];
      default: tgt_full = 1'b1;
    endcase
  end

  // Ready is combinational on the target's full flag so a write and a new accept share one edge.
  assign din_rdy = rst_ok & ((state_q == IDLE) | ~tgt_full);
  assign accept  = din_vld & din_rdy;
  assign drain   = (state_q == HOLD) & ~tgt_full;

  assign wr_en[0] = drain & (stage_chan_q == CH_A);
  assign wr_en[1] = drain & (stage_chan_q == CH_B);
  assign wr_en[2] = drain & (stage_chan_q == CH_C);

  always_ff @(posedge clkd or negedge rst_ok) begin
    if (!rst_ok) begin
      state_q      <= IDLE;
      stage_data_q <= '0;
      stage_chan_q <= CH_A;
    end else if (accept && (din_channel != CH_NONE)) begin
      state_q      <= HOLD;
      stage_data_q <= din;
      stage_chan_q <= din_channel;
    end else if (drain) begin
      state_q      <= IDLE;
    end
  end

`ifdef DIST_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clkd or negedge rst_ok) begin
    if (!rst_ok)
      err_cnt_q <= '0;
    else if (accept && (din_channel == CH_NONE) && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

  async_fifo_gray #(.DW(DW), .AW(AW)) u_fifo_a (
    .wr_clk_i  (clkd),
    .rd_clk_i  (clka),
    .rst_n_i   (rst_n),
    .wr_en_i   (wr_en[0]),
    .wr_data_i (stage_data_q),
    .full_o    (full[0]),
    .rd_data_o (dout_a),
    .rd_vld_o  (dout_a_vld)
  );

  async_fifo_gray #(.DW(DW), .AW(AW)) u_fifo_b (
    .wr_clk_i  (clkd),
    .rd_clk_i  (clkb),
    .rst_n_i   (rst_n),
    .wr_en_i   (wr_en[1]),
    .wr_data_i (stage_data_q),
    .full_o    (full[1]),
    .rd_data_o (dout_b),
    .rd_vld_o  (dout_b_vld)
  );

  async_fifo_gray #(.DW(DW), .AW(AW)) u_fifo_c (
    .wr_clk_i  (clkd),
    .rd_clk_i  (clkc),
    .rst_n_i   (rst_n),
    .wr_en_i   (wr_en[2]),
    .wr_data_i (stage_data_q),
    .full_o    (full[2]),
    .rd_data_o (dout_c),
    .rd_vld_o  (dout_c_vld)
  );

endmodule
